// File: rtl/arm_pipe_pkg.sv
// Shared types and constants for the fetch/decode slice of the ARM pipeline.
package arm_pipe_pkg;

    localparam int unsigned INSTR_W = 32;

    localparam logic [INSTR_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [INSTR_W-1:0] PC_STEP          = 32'd4;

    typedef enum logic [1:0] {
        F_IDLE,
        F_REQ,
        F_DRAIN
    } fetch_state_t;

    // One prefetched instruction together with the address it came from.
    typedef struct packed {
        logic [INSTR_W-1:0] pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    // Clears the byte-offset bits of an address.
    function automatic logic [INSTR_W-1:0] word_align(input logic [INSTR_W-1:0] addr);
        return addr & ~32'h3;
    endfunction

endpackage

// File: rtl/issue_fetch_if.sv
// Instruction-memory bus and decode handshake between the issuer and its neighbours.
interface issue_fetch_if;
    import arm_pipe_pkg::*;

    logic               imem_req;
    logic [INSTR_W-1:0] imem_addr;
    logic               imem_ack;
    logic [INSTR_W-1:0] imem_rdata;
    logic [INSTR_W-1:0] instr_out;
    logic [INSTR_W-1:0] instr_pc_out;
    logic               ready_out;
    logic               trigger_in;

    // Issuer side.
    modport master (
        output imem_req, imem_addr, instr_out, instr_pc_out, ready_out,
        input  imem_ack, imem_rdata, trigger_in
    );

    // Memory / decode side.
    modport slave (
        input  imem_req, imem_addr, instr_out, instr_pc_out, ready_out,
        output imem_ack, imem_rdata, trigger_in
    );

endinterface

// File: rtl/prefetch_fifo.sv
// DEPTH-entry synchronous FIFO of {pc, instr} pairs with a flush input.
module prefetch_fifo
    import arm_pipe_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clr,
    input  logic                  push,
    input  fetch_entry_t          push_data,
    input  logic                  pop,
    output logic [$clog2(DEPTH):0] count,
    output fetch_entry_t          head
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_C = (PTR_W+1)'(DEPTH);

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !clr && (count_q != FULL_C);
    assign do_pop  = pop  && !clr && (count_q != '0);

    // Pointer and occupancy bookkeeping; a flush empties the queue in one cycle.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Entry storage; contents need no reset because occupancy gates every read.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/issue_fetch.sv
// Sequential instruction fetcher with prefetch queue and toggle-handshake issue to decode.
module issue_fetch
    import arm_pipe_pkg::*;
#(
    parameter int unsigned        DEPTH    = 2,
    parameter logic [INSTR_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic               clk,
    input  logic               reset,
    issue_fetch_if.master      bus,
    input  logic               branch_valid,
    input  logic [INSTR_W-1:0] branch_target,
    output logic               proto_err
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    fetch_state_t       state_q, state_d;
    logic [INSTR_W-1:0] pc_q, pc_d;
    logic [INSTR_W-1:0] addr_q, addr_d;
    logic               req_q, req_d;

    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [INSTR_W-1:0] ipc_q, ipc_d;
    logic               ready_q, ready_d;
    logic               perr_q, perr_d;

    logic               sync1_q, sync2_q, sync3_q;
    logic               trig_edge;

    logic               fifo_push;
    logic               fifo_pop;
    logic [CNT_W-1:0]   fifo_count;
    fetch_entry_t       fifo_head;
    fetch_entry_t       push_data;

    assign push_data = '{pc: pc_q, instr: bus.imem_rdata};
    assign trig_edge = sync2_q ^ sync3_q;

    prefetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .clr       (branch_valid),
        .push      (fifo_push),
        .push_data (push_data),
        .pop       (fifo_pop),
        .count     (fifo_count),
        .head      (fifo_head)
    );

    // Two-flop synchronizer for the decode toggle plus a history flop for edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= bus.trigger_in;
            sync2_q <= bus.trigger_in;
            sync3_q <= bus.trigger_in;
        end else begin
            sync1_q <= bus.trigger_in;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    // Fetch FSM next-state: one outstanding request at a time, drained on redirect.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        addr_d    = addr_q;
        req_d     = req_q;
        fifo_push = 1'b0;
        case (state_q)
            F_IDLE: begin
                // Stay idle on a redirect so the next request goes to the new target.
                if (!branch_valid && (fifo_count < DEPTH_C)) begin
                    state_d = F_REQ;
                    addr_d  = pc_q;
                    req_d   = 1'b1;
                end
            end
            F_REQ: begin
                if (branch_valid) begin
                    // An ack coinciding with the redirect already retires the request.
                    if (bus.imem_ack) begin
                        state_d = F_IDLE;
                        req_d   = 1'b0;
                    end else begin
                        state_d = F_DRAIN;
                    end
                end else if (bus.imem_ack) begin
                    fifo_push = 1'b1;
                    pc_d      = pc_q + PC_STEP;
                    req_d     = 1'b0;
                    state_d   = F_IDLE;
                end
            end
            F_DRAIN: begin
                if (bus.imem_ack) begin
                    req_d   = 1'b0;
                    state_d = F_IDLE;
                end
            end
            default: begin
                state_d = F_IDLE;
                req_d   = 1'b0;
            end
        endcase
        if (branch_valid) pc_d = word_align(branch_target);
    end

    // Fetch FSM and PC registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= F_IDLE;
            pc_q    <= RESET_PC;
            addr_q  <= RESET_PC;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            req_q   <= req_d;
        end
    end

    // Presentation next-state: load the head when idle, pop on a consume edge, flush on redirect.
    always_comb begin
        instr_d  = instr_q;
        ipc_d    = ipc_q;
        ready_d  = ready_q;
        perr_d   = perr_q;
        fifo_pop = 1'b0;
        if (branch_valid) begin
            ready_d = 1'b0;
        end else if (trig_edge && ready_q) begin
            fifo_pop = 1'b1;
            ready_d  = 1'b0;
        end else begin
            if (trig_edge) perr_d = 1'b1;
            if (!ready_q && (fifo_count != '0)) begin
                instr_d = fifo_head.instr;
                ipc_d   = fifo_head.pc;
                ready_d = 1'b1;
            end
        end
    end

    // Presentation registers toward decode.
    always_ff @(posedge clk) begin
        if (reset) begin
            instr_q <= '0;
            ipc_q   <= '0;
            ready_q <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            instr_q <= instr_d;
            ipc_q   <= ipc_d;
            ready_q <= ready_d;
            perr_q  <= perr_d;
        end
    end

    assign bus.imem_req     = req_q;
    assign bus.imem_addr    = addr_q;
    assign bus.instr_out    = instr_q;
    assign bus.instr_pc_out = ipc_q;
    assign bus.ready_out    = ready_q;
    assign proto_err        = perr_q;

endmodule

// File: tb/tb_issue_fetch.sv
// Self-checking bench for issue_fetch: directed cycle table, hand sequences and a random run.
module tb_issue_fetch;
    import arm_pipe_pkg::*;

    localparam logic [31:0] RPC_B = 32'hFFFF_FFF8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a = 1'b1, rst_b = 1'b1;
    logic        br_a = 1'b0, br_b = 1'b0;
    logic [31:0] bt_a = '0, bt_b = '0;
    logic        perr_a, perr_b;
    logic        trig_a = 1'b0, trig_b = 1'b0;
    logic        ack_a = 1'b0, ack_b = 1'b0;
    logic [31:0] rdata_a = '0, rdata_b = '0;
    logic        hold [2];
    int unsigned max_wait [2];
    int unsigned wcnt_a = 0, wcnt_b = 0;

    int unsigned n_pass = 0;
    int unsigned n_total = 0;

    issue_fetch_if bus_a ();
    issue_fetch_if bus_b ();

    assign bus_a.imem_ack   = ack_a;
    assign bus_a.imem_rdata = rdata_a;
    assign bus_a.trigger_in = trig_a;
    assign bus_b.imem_ack   = ack_b;
    assign bus_b.imem_rdata = rdata_b;
    assign bus_b.trigger_in = trig_b;

    issue_fetch #(.DEPTH(2), .RESET_PC(32'h0000_0000)) dut_a (
        .clk(clk), .reset(rst_a), .bus(bus_a),
        .branch_valid(br_a), .branch_target(bt_a), .proto_err(perr_a)
    );

    issue_fetch #(.DEPTH(4), .RESET_PC(RPC_B)) dut_b (
        .clk(clk), .reset(rst_b), .bus(bus_b),
        .branch_valid(br_b), .branch_target(bt_b), .proto_err(perr_b)
    );

    // Memory contents as a function of address; address 0 holds 32'hE3A0_0001.
    function automatic logic [31:0] memf(input logic [31:0] a);
        return 32'hE3A0_0001 ^ (a * 32'h9E37_79B1);
    endfunction

    // Memory A: acks a held request after a random number of wait cycles.
    always @(negedge clk) begin
        if (ack_a) ack_a = 1'b0;
        else if (bus_a.imem_req && !hold[0]) begin
            if (wcnt_a == 0) begin
                ack_a   = 1'b1;
                rdata_a = memf(bus_a.imem_addr);
                wcnt_a  = $urandom_range(0, max_wait[0]);
            end else wcnt_a = wcnt_a - 1;
        end
    end

    // Memory B: same behaviour for the second instance.
    always @(negedge clk) begin
        if (ack_b) ack_b = 1'b0;
        else if (bus_b.imem_req && !hold[1]) begin
            if (wcnt_b == 0) begin
                ack_b   = 1'b1;
                rdata_b = memf(bus_b.imem_addr);
                wcnt_b  = $urandom_range(0, max_wait[1]);
            end else wcnt_b = wcnt_b - 1;
        end
    end

    function automatic logic rdy(input int d);
        return (d != 0) ? bus_b.ready_out : bus_a.ready_out;
    endfunction
    function automatic logic [31:0] opc(input int d);
        return (d != 0) ? bus_b.instr_pc_out : bus_a.instr_pc_out;
    endfunction
    function automatic logic [31:0] oins(input int d);
        return (d != 0) ? bus_b.instr_out : bus_a.instr_out;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic toggle(input int d);
        if (d != 0) trig_b = ~trig_b;
        else        trig_a = ~trig_a;
    endtask

    // Consume the presented instruction: ready holds two cycles, falls on the third edge.
    task automatic consume(input int d);
        toggle(d);
        tick();
        check("consume_hold1", {31'b0, rdy(d)}, 32'd1);
        tick();
        check("consume_hold2", {31'b0, rdy(d)}, 32'd1);
        tick();
        check("consume_pop", {31'b0, rdy(d)}, 32'd0);
    endtask

    task automatic wait_ready(input int d, input int unsigned lim, input string name);
        int unsigned k = 0;
        while (!rdy(d) && k < lim) begin
            tick();
            k++;
        end
        if (!rdy(d)) check(name, {31'b0, rdy(d)}, 32'd1);
    endtask

    task automatic branch_a(input logic [31:0] tgt);
        br_a = 1'b1;
        bt_a = tgt;
        tick();
        br_a = 1'b0;
        check("branch_ready_fall", {31'b0, bus_a.ready_out}, 32'd0);
    endtask

    task automatic check_reset_vals(input int d, input logic [31:0] rpc);
        if (d != 0) begin
            check("rst_req_b",  {31'b0, bus_b.imem_req}, 32'd0);
            check("rst_addr_b", bus_b.imem_addr, rpc);
            check("rst_perr_b", {31'b0, perr_b}, 32'd0);
        end else begin
            check("rst_req_a",  {31'b0, bus_a.imem_req}, 32'd0);
            check("rst_addr_a", bus_a.imem_addr, rpc);
            check("rst_perr_a", {31'b0, perr_a}, 32'd0);
        end
        check("rst_ready", {31'b0, rdy(d)}, 32'd0);
        check("rst_instr", oins(d), 32'd0);
        check("rst_ipc",   opc(d), 32'd0);
    endtask

    typedef struct {
        logic        tgl;
        logic        req;
        logic [31:0] addr;
        logic        rdy;
        logic [31:0] pc;
    } vec_t;

    vec_t tbl [18];

    initial begin
        logic [31:0] exp_pc;
        logic [31:0] tgt;
        logic [31:0] wrap_pcs [3];

        hold[0] = 1'b0; hold[1] = 1'b0;
        max_wait[0] = 0; max_wait[1] = 0;

        // Cycle n after reset release, zero-wait memory, decode consumes as soon as ready.
        tbl[0]  = '{1'b0, 1'b1, 32'h0,  1'b0, 32'h0};
        tbl[1]  = '{1'b0, 1'b0, 32'h0,  1'b0, 32'h0};
        tbl[2]  = '{1'b1, 1'b1, 32'h4,  1'b1, 32'h0};
        tbl[3]  = '{1'b0, 1'b0, 32'h0,  1'b1, 32'h0};
        tbl[4]  = '{1'b0, 1'b0, 32'h0,  1'b1, 32'h0};
        tbl[5]  = '{1'b0, 1'b0, 32'h0,  1'b0, 32'h0};
        tbl[6]  = '{1'b1, 1'b1, 32'h8,  1'b1, 32'h4};
        tbl[7]  = '{1'b0, 1'b0, 32'h0,  1'b1, 32'h4};
        tbl[8]  = '{1'b0, 1'b0, 32'h0,  1'b1, 32'h4};
        tbl[9]  = '{1'b0, 1'b0, 32'h0,  1'b0, 32'h0};
        tbl[10] = '{1'b1, 1'b1, 32'hC,  1'b1, 32'h8};
        tbl[11] = '{1'b0, 1'b0, 32'h0,  1'b1, 32'h8};
        tbl[12] = '{1'b0, 1'b0, 32'h0,  1'b1, 32'h8};
        tbl[13] = '{1'b0, 1'b0, 32'h0,  1'b0, 32'h0};
        tbl[14] = '{1'b1, 1'b1, 32'h10, 1'b1, 32'hC};
        tbl[15] = '{1'b0, 1'b0, 32'h0,  1'b1, 32'hC};
        tbl[16] = '{1'b0, 1'b0, 32'h0,  1'b1, 32'hC};
        tbl[17] = '{1'b0, 1'b0, 32'h0,  1'b0, 32'h0};

        repeat (3) tick();
        check_reset_vals(0, 32'h0);
        check_reset_vals(1, RPC_B);

        // Directed table on instance A.
        rst_a = 1'b0;
        for (int i = 0; i < 18; i++) begin
            tick();
            check("tbl_req", {31'b0, bus_a.imem_req}, {31'b0, tbl[i].req});
            if (tbl[i].req) check("tbl_addr", bus_a.imem_addr, tbl[i].addr);
            check("tbl_ready", {31'b0, bus_a.ready_out}, {31'b0, tbl[i].rdy});
            if (tbl[i].rdy) begin
                check("tbl_pc", bus_a.instr_pc_out, tbl[i].pc);
                check("tbl_instr", bus_a.instr_out, memf(tbl[i].pc));
            end
            if (tbl[i].tgl) toggle(0);
        end

        // Redirect while the fetch of 0x8 is outstanding.
        rst_a = 1'b1;
        tick();
        rst_a = 1'b0;
        repeat (3) tick();
        check("br_first_instr", bus_a.instr_out, 32'hE3A0_0001);
        toggle(0);
        tick();
        hold[0] = 1'b1;
        repeat (3) tick();
        check("br_pre_pc", bus_a.instr_pc_out, 32'h4);
        check("br_pre_addr", bus_a.imem_addr, 32'h8);
        branch_a(32'h0000_0103);
        check("br_drain_req", {31'b0, bus_a.imem_req}, 32'd1);
        check("br_drain_addr", bus_a.imem_addr, 32'h8);
        hold[0] = 1'b0;
        tick();
        check("br_drained", {31'b0, bus_a.imem_req}, 32'd0);
        check("br_no_stale", {31'b0, bus_a.ready_out}, 32'd0);
        tick();
        check("br_tgt_req", {31'b0, bus_a.imem_req}, 32'd1);
        check("br_tgt_addr", bus_a.imem_addr, 32'h100);
        repeat (2) tick();
        check("br_tgt_ready", {31'b0, bus_a.ready_out}, 32'd1);
        check("br_tgt_pc", bus_a.instr_pc_out, 32'h100);
        check("br_tgt_instr", bus_a.instr_out, memf(32'h100));

        // Trigger while nothing is presented: flagged, nothing popped.
        hold[0] = 1'b1;
        branch_a(32'h0000_0200);
        repeat (2) tick();
        toggle(0);
        repeat (5) tick();
        check("perr_set", {31'b0, perr_a}, 32'd1);
        check("perr_ready", {31'b0, bus_a.ready_out}, 32'd0);
        hold[0] = 1'b0;
        wait_ready(0, 20, "perr_wait");
        check("perr_pc_kept", bus_a.instr_pc_out, 32'h200);
        check("perr_instr", bus_a.instr_out, memf(32'h200));
        consume(0);
        wait_ready(0, 20, "perr_wait2");
        check("perr_next_pc", bus_a.instr_pc_out, 32'h204);
        check("perr_sticky", {31'b0, perr_a}, 32'd1);

        // Random traffic against a sequential-PC stream model.
        rst_a = 1'b1;
        repeat (2) tick();
        rst_a = 1'b0;
        check("perr_cleared", {31'b0, perr_a}, 32'd0);
        max_wait[0] = 3;
        exp_pc = 32'h0;
        for (int t = 0; t < 300; t++) begin
            wait_ready(0, 60, "rnd_wait");
            if (!bus_a.ready_out) break;
            repeat ($urandom_range(0, 2)) tick();
            if ($urandom_range(0, 9) == 0) begin
                tgt = $urandom;
                branch_a(tgt);
                exp_pc = tgt & 32'hFFFF_FFFC;
            end else begin
                check("rnd_pc", bus_a.instr_pc_out, exp_pc);
                check("rnd_instr", bus_a.instr_out, memf(exp_pc));
                consume(0);
                exp_pc = exp_pc + 32'd4;
                if ($urandom_range(0, 7) == 0) begin
                    tgt = $urandom;
                    branch_a(tgt);
                    exp_pc = tgt & 32'hFFFF_FFFC;
                end
            end
        end
        check("rnd_no_perr", {31'b0, perr_a}, 32'd0);

        // Instance B: reset while a fetch is outstanding with two entries queued.
        rst_b = 1'b0;
        tick();
        check("b_first_req", {31'b0, bus_b.imem_req}, 32'd1);
        check("b_first_addr", bus_b.imem_addr, RPC_B);
        repeat (2) tick();
        check("b_ready_pc", bus_b.instr_pc_out, RPC_B);
        tick();
        hold[1] = 1'b1;
        tick();
        check("b_wrap_req", {31'b0, bus_b.imem_req}, 32'd1);
        check("b_wrap_addr", bus_b.imem_addr, 32'h0);
        rst_b = 1'b1;
        tick();
        rst_b = 1'b0;
        check_reset_vals(1, RPC_B);
        hold[1] = 1'b0;
        tick();
        check("b_restart_req", {31'b0, bus_b.imem_req}, 32'd1);
        check("b_restart_addr", bus_b.imem_addr, RPC_B);
        wrap_pcs[0] = 32'hFFFF_FFF8;
        wrap_pcs[1] = 32'hFFFF_FFFC;
        wrap_pcs[2] = 32'h0000_0000;
        for (int k = 0; k < 3; k++) begin
            wait_ready(1, 20, "b_wait");
            check("b_wrap_pc", bus_b.instr_pc_out, wrap_pcs[k]);
            check("b_wrap_instr", bus_b.instr_out, memf(wrap_pcs[k]));
            consume(1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
